formant_scheduler: RTL and testbench

Frame-level controller between the FFT magnitude stream and the formant engine. It captures each I-sample FFT frame into a ping-pong buffer and replays a frame to the engine as one gap-free I-cycle burst, only when the engine is idle. It then waits for the engine's result, recovers the engine on timeout, and drops whole frames when both buffers are occupied. It sits directly upstream of `formant` and owns that engine's launch and recovery.

---
 rtl/formant_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_formant_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/formant_scheduler.sv
// formant_scheduler: captures FFT frames into a two-bank buffer and replays each one to
// the formant engine as a gap-free burst, then collects the result or recovers the engine.
module formant_scheduler #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int FORMANTS  = 5,
  parameter int TIMEOUT   = 1000000
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          in_valid,
  input  logic [BIT_WIDTH-1:0]          in_data,
  output logic                          fft_valid,
  output logic [BIT_WIDTH-1:0]          fft_data,
  input  logic                          eng_formant_valid,
  input  logic [BIT_WIDTH*FORMANTS-1:0] eng_formant_freq,
  output logic                          eng_rst,
  output logic                          out_valid,
  output logic [BIT_WIDTH*FORMANTS-1:0] out_freq,
  output logic                          busy,
  output logic [15:0]                   frames_dropped,
  output logic [15:0]                   timeouts
);

  localparam int DEPTH = 2 * I;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(I + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int FW    = BIT_WIDTH * FORMANTS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_GAP,
    S_RECOVER
  } state_t;

  logic [BIT_WIDTH-1:0] r_mem [DEPTH];
  logic [BIT_WIDTH-1:0] r_rd_q;

  logic [1:0]    r_bank_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [CW-1:0] r_wr_cnt;
  logic          r_discard;
  logic [15:0]   r_frames_dropped;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_rd_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_fft_valid;
  logic          r_out_valid;
  logic [FW-1:0] r_out_freq;
  logic          r_eng_rst;
  logic          r_busy;
  logic [15:0]   r_timeouts;

  logic          w_discard;
  logic          w_frame_end;
  logic          w_wr_en;
  logic          w_set;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_en;
  logic          w_clr;
  logic          w_result;
  logic          w_timeout;
  logic [1:0]    w_set_mask;
  logic [1:0]    w_clr_mask;

  // The keep/discard decision is taken on the first sample and held for the whole frame.
  assign w_discard   = (r_wr_cnt == '0) ? r_bank_full[r_wr_bank] : r_discard;
  assign w_frame_end = in_valid && (r_wr_cnt == CW'(I - 1));
  assign w_wr_en     = in_valid && !w_discard;
  assign w_set       = w_wr_en && w_frame_end;
  assign w_wr_addr   = r_wr_bank ? AW'(I) + AW'(r_wr_cnt) : AW'(r_wr_cnt);
  assign w_rd_addr   = r_rd_bank ? AW'(I) + AW'(r_rd_cnt) : AW'(r_rd_cnt);

  always_ff @(posedge clk_in) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_rd_en) begin
      r_rd_q <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_cnt         <= '0;
      r_wr_bank        <= 1'b0;
      r_discard        <= 1'b0;
      r_frames_dropped <= '0;
    end else if (in_valid) begin
      r_discard <= w_discard;
      r_wr_cnt  <= w_frame_end ? '0 : r_wr_cnt + 1'b1;
      if (w_frame_end && !w_discard) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_frame_end && w_discard && (r_frames_dropped != 16'hFFFF)) begin
        r_frames_dropped <= r_frames_dropped + 16'd1;
      end
    end
  end

  // Writer only sets a non-full bank and reader only clears a full one, so they never collide.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flag
      assign w_set_mask[gi] = w_set && (r_wr_bank == 1'(gi));
      assign w_clr_mask[gi] = w_clr && (r_rd_bank == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_bank_full <= 2'b00;
    end else begin
      r_bank_full <= (r_bank_full | w_set_mask) & ~w_clr_mask;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_clr        = 1'b0;
    w_result     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_bank_full[r_rd_bank]) begin
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        // The extra cycle at count I is the one in which the last sample is on fft_data.
        if (r_rd_cnt == CW'(I)) begin
          w_clr        = 1'b1;
          w_state_next = S_WAIT;
        end else begin
          w_rd_en = 1'b1;
        end
      end
      S_WAIT: begin
        if (eng_formant_valid) begin
          w_result     = 1'b1;
          w_state_next = S_GAP;
        end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = S_RECOVER;
        end
      end
      S_GAP: begin
        w_state_next = S_IDLE;
      end
      S_RECOVER: begin
        if (r_to_cnt == TW'(1)) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_rd_cnt    <= '0;
      r_to_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_fft_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_freq  <= '0;
      r_eng_rst   <= 1'b0;
      r_busy      <= 1'b0;
      r_timeouts  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rd_cnt    <= w_rd_en ? r_rd_cnt + 1'b1 : '0;
      r_fft_valid <= w_rd_en;
      r_out_valid <= w_result;
      r_eng_rst   <= (w_state_next == S_RECOVER);
      r_busy      <= (w_state_next != S_IDLE);
      // One counter serves both the WAIT timeout and the RECOVER length.
      if ((r_state == w_state_next) && ((r_state == S_WAIT) || (r_state == S_RECOVER))) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_clr) begin
        r_rd_bank <= ~r_rd_bank;
      end
      if (w_result) begin
        r_out_freq <= eng_formant_freq;
      end
      if (w_timeout && (r_timeouts != 16'hFFFF)) begin
        r_timeouts <= r_timeouts + 16'd1;
      end
    end
  end

  assign fft_valid      = r_fft_valid;
  assign fft_data       = r_fft_valid ? r_rd_q : '0;
  assign eng_rst        = r_eng_rst;
  assign out_valid      = r_out_valid;
  assign out_freq       = r_out_freq;
  assign busy           = r_busy;
  assign frames_dropped = r_frames_dropped;
  assign timeouts       = r_timeouts;

endmodule

// File: tb/tb_formant_scheduler.sv
// Scoreboard bench for formant_scheduler: a frame-level timing model predicts bursts,
// results, recoveries and drops; a monitor compares them against what the DUT emits.
module tb_formant_scheduler;

  localparam int BW = 32;
  localparam int NI = 160;
  localparam int NF = 5;
  localparam int TO = 1000;
  localparam int FW = BW * NF;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          fft_valid;
  logic [BW-1:0] fft_data;
  logic          eng_formant_valid = 1'b0;
  logic [FW-1:0] eng_formant_freq = '0;
  logic          eng_rst;
  logic          out_valid;
  logic [FW-1:0] out_freq;
  logic          busy;
  logic [15:0]   frames_dropped;
  logic [15:0]   timeouts;

  formant_scheduler #(
    .BIT_WIDTH(BW),
    .I(NI),
    .FORMANTS(NF),
    .TIMEOUT(TO)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .in_valid(in_valid),
    .in_data(in_data),
    .fft_valid(fft_valid),
    .fft_data(fft_data),
    .eng_formant_valid(eng_formant_valid),
    .eng_formant_freq(eng_formant_freq),
    .eng_rst(eng_rst),
    .out_valid(out_valid),
    .out_freq(out_freq),
    .busy(busy),
    .frames_dropped(frames_dropped),
    .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [BW-1:0] data; } beat_t;
  typedef struct { int cyc; logic [FW-1:0] freq; } res_t;

  beat_t         exp_fft[$];
  res_t          exp_res[$];
  int            exp_rst[$];
  int            free_at[$];
  logic [FW-1:0] pulse_at [int];
  int            idle_at = 0;
  int            n_drop = 0;
  int            n_to = 0;
  int            frame_id = 0;
  logic [FW-1:0] last_freq = '0;
  int            total = 0;
  int            bad = 0;

  function automatic logic [FW-1:0] rand_freq();
    logic [FW-1:0] v;
    for (int k = 0; k < NF; k++) v[k*BW +: BW] = $urandom();
    return v;
  endfunction

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an output pulse, want none (cycle %0d)", name, cyc);
  endtask

  // Engine stand-in: fires only the pulses the model has scheduled, random noise otherwise.
  initial forever begin
    @(posedge clk);
    #1;
    if (pulse_at.exists(cyc)) begin
      eng_formant_valid = 1'b1;
      eng_formant_freq  = pulse_at[cyc];
      pulse_at.delete(cyc);
    end else begin
      eng_formant_valid = 1'b0;
      eng_formant_freq  = rand_freq();
    end
  end

  always @(negedge clk) begin : mon
    beat_t b;
    res_t  r;
    int    rc;
    if (!rst_in) begin
      if (fft_valid) begin
        if (exp_fft.size() == 0) unexpected("fft_unexpected");
        else begin
          b = exp_fft.pop_front();
          check_int("fft_cycle", cyc, b.cyc);
          check("fft_data", FW'(fft_data), FW'(b.data));
          check("busy_in_burst", FW'(busy), FW'(1));
        end
      end
      if (out_valid) begin
        if (exp_res.size() == 0) unexpected("out_unexpected");
        else begin
          r = exp_res.pop_front();
          check_int("out_cycle", cyc, r.cyc);
          check("out_freq", out_freq, r.freq);
          last_freq = r.freq;
        end
      end else begin
        check("out_freq_hold", out_freq, last_freq);
      end
      if (eng_rst) begin
        if (exp_rst.size() == 0) unexpected("eng_rst_unexpected");
        else begin
          rc = exp_rst.pop_front();
          check_int("eng_rst_cycle", cyc, rc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // lat < 0 means the engine never answers; n_samp < NI sends a partial frame only.
  task automatic send_frame(input int n_samp, input int lat, input bit ramp,
                            input int gap_max, input bit spur, output int c_out);
    logic [BW-1:0] data[$];
    int s, t, c, w, g;
    bit drop;
    c_out = -1;
    s = 0;
    drop = 1'b0;
    for (int n = 0; n < n_samp; n++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      idle(g);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = ramp ? BW'(n) : $urandom();
      data.push_back(in_data);
      if (n == 0) begin
        s = cyc;
        while (free_at.size() > 0 && free_at[0] <= s) void'(free_at.pop_front());
        drop = (free_at.size() >= 2);
      end
    end
    t = cyc;
    frame_id++;
    if (n_samp < NI) begin
      $display("frame %0d: partial, %0d samples, first at cycle %0d", frame_id, n_samp, s);
      return;
    end
    if (drop) begin
      n_drop++;
      $display("frame %0d: cycles %0d..%0d, dropped", frame_id, s, t);
      return;
    end
    c = (t + 1 > idle_at) ? t + 1 : idle_at;
    for (int k = 0; k < NI; k++) exp_fft.push_back('{c + 2 + k, data[k]});
    free_at.push_back(c + 2 + NI);
    if (lat >= 0) begin
      res_t r;
      w = c + 2 + NI + lat;
      r.cyc  = w + 1;
      r.freq = rand_freq();
      pulse_at[w] = r.freq;
      exp_res.push_back(r);
      idle_at = w + 2;
    end else begin
      exp_rst.push_back(c + 2 + NI + TO);
      exp_rst.push_back(c + 3 + NI + TO);
      idle_at = c + 4 + NI + TO;
      n_to++;
    end
    if (spur) pulse_at[c + 1 + int'($urandom_range(0, NI))] = rand_freq();
    c_out = c;
    $display("frame %0d: cycles %0d..%0d, burst from %0d, latency %0d", frame_id, s, t, c + 2, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fft_valid"}, FW'(fft_valid), '0);
    check({tag, "_fft_data"}, FW'(fft_data), '0);
    check({tag, "_eng_rst"}, FW'(eng_rst), '0);
    check({tag, "_out_valid"}, FW'(out_valid), '0);
    check({tag, "_out_freq"}, out_freq, '0);
    check({tag, "_busy"}, FW'(busy), '0);
    check({tag, "_frames_dropped"}, FW'(frames_dropped), '0);
    check({tag, "_timeouts"}, FW'(timeouts), '0);
  endtask

  task automatic drain(input string tag);
    while (cyc < idle_at + 2) idle(1);
    idle(4);
    check_int({tag, "_bursts_left"}, exp_fft.size(), 0);
    check_int({tag, "_results_left"}, exp_res.size(), 0);
    check_int({tag, "_recoveries_left"}, exp_rst.size(), 0);
    check_int({tag, "_frames_dropped"}, int'(frames_dropped), n_drop);
    check_int({tag, "_timeouts"}, int'(timeouts), n_to);
    check({tag, "_busy_idle"}, FW'(busy), '0);
    $display("phase %s: drops=%0d timeouts=%0d at cycle %0d", tag, n_drop, n_to, cyc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_in   = 1'b1;
    in_valid = 1'b0;
    exp_fft.delete();
    exp_res.delete();
    exp_rst.delete();
    free_at.delete();
    pulse_at.delete();
    idle_at   = 0;
    n_drop    = 0;
    n_to      = 0;
    last_freq = '0;
    #1;
    check_reset_outputs("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c, ca, lat, r;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_in = 1'b0;

    // Engine pulses while the scheduler is idle must be ignored.
    pulse_at[cyc + 2] = rand_freq();
    pulse_at[cyc + 5] = rand_freq();
    idle(8);

    send_frame(NI, 500, 1'b1, 0, 1'b1, c);
    drain("single");

    repeat (3) send_frame(NI, 900, 1'b0, 0, 1'b0, c);
    drain("three");

    send_frame(NI, -1, 1'b0, 0, 1'b1, c);
    send_frame(NI, TO - 1, 1'b0, 0, 1'b0, c);
    drain("timeout");

    // Second frame completes in the same cycle as the first frame's final burst beat.
    send_frame(NI, 50, 1'b0, 0, 1'b0, ca);
    while (cyc < ca + 1) idle(1);
    send_frame(NI, 60, 1'b0, 0, 1'b0, c);
    drain("coincident");

    for (int f = 0; f < 12; f++) begin
      r   = int'($urandom_range(0, 4));
      lat = (r == 0) ? -1 : int'($urandom_range(0, 700));
      send_frame(NI, lat, 1'b0, int'($urandom_range(0, 2)), 1'(r[0]), c);
      idle(int'($urandom_range(0, 400)));
    end
    drain("random");

    send_frame(NI, 300, 1'b0, 0, 1'b1, c);
    send_frame(80, 0, 1'b0, 0, 1'b0, c);
    do_reset();
    send_frame(NI, 100, 1'b1, 0, 1'b0, c);
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
